// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of the ALU: latches one decoded instruction,
// reads operands from the local register file, drives the ALU, writes back and reports status.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned IMM_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_alu_op,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic              i_use_imm,
  input  logic [IMM_W-1:0]  i_imm,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [3:0]        o_alu_op,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_overflow,
  output logic              o_status_valid,
  output logic [1:0]        o_status,
  output logic              o_halted,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  localparam int unsigned EXT_W = DATA_W - IMM_W;
  localparam logic [1:0]  ST_OK  = 2'b00;
  localparam logic [1:0]  ST_OVF = 2'b01;
  localparam logic [1:0]  ST_INV = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic              use_imm_q, use_imm_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [1:0]        status_q, status_d;
  logic              ready_q, ready_d;
  logic              status_valid_q, status_valid_d;
  logic              halted_q, halted_d;
  logic              rf_we;
  logic              op_invalid;
  logic [DATA_W-1:0] rf_q [REG_NUM];

  // Opcodes the ALU does not implement
  assign op_invalid = (op_q == 4'd6) || (op_q == 4'd13) || (op_q == 4'd14) || (op_q == 4'd15);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    result_d  = result_q;
    status_d  = status_q;
    rf_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          op_d      = i_alu_op;
          rd_d      = i_rd;
          rs1_d     = i_rs1;
          rs2_d     = i_rs2;
          use_imm_d = i_use_imm;
          imm_d     = {{EXT_W{i_imm[IMM_W-1]}}, i_imm};
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (op_invalid) begin
          status_d = ST_INV;
          state_d  = S_WB;
        end else begin
          alu_a_d  = rf_q[rs1_q];
          alu_b_d  = use_imm_q ? imm_q : rf_q[rs2_q];
          alu_op_d = op_q;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = i_alu_result;
        status_d = i_alu_overflow ? ST_OVF : ST_OK;
        state_d  = S_WB;
      end
      S_WB: begin
        if (status_q == ST_OK) begin
          rf_we   = (rd_q != '0);
          state_d = S_IDLE;
        end else begin
          state_d = S_HALT;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Status/handshake outputs are registered copies of the next state
    ready_d        = (state_d == S_IDLE);
    status_valid_d = (state_d == S_WB);
    halted_d       = (state_d == S_HALT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q           <= '0;
      rd_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      use_imm_q      <= 1'b0;
      imm_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      result_q       <= '0;
      status_q       <= ST_OK;
      ready_q        <= 1'b1;
      status_valid_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      op_q           <= op_d;
      rd_q           <= rd_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      use_imm_q      <= use_imm_d;
      imm_q          <= imm_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      result_q       <= result_d;
      status_q       <= status_d;
      ready_q        <= ready_d;
      status_valid_q <= status_valid_d;
      halted_q       <= halted_d;
    end
  end

  // Register file; r0 is never written so it always reads 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(REG_NUM); i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd_q] <= result_q;
    end
  end

  assign o_ready        = ready_q;
  assign o_alu_a        = alu_a_q;
  assign o_alu_b        = alu_b_q;
  assign o_alu_op       = alu_op_q;
  assign o_status_valid = status_valid_q;
  assign o_status       = status_q;
  assign o_halted       = halted_q;
  assign o_dbg_data     = (i_dbg_addr == '0) ? '0 : rf_q[i_dbg_addr];

endmodule
